// File: rtl/asip_hazard_unit.sv
// asip_hazard_unit
//   Hazard detection and forwarding control for the 5-stage ASIP pipeline
//   (F, D, E, M, W). It keeps a shadow copy of the destination-register state
//   of the E, M and W stages. From that state it finds RAW and load-use
//   hazards for the instruction in D.
//
// Build option:
//   ASIP_FWD_EN  defined   -> E/M forwarding is enabled; only load-use stalls.
//                undefined -> no forwarding; any E/M/W producer match stalls D.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   dec_valid                 a real instruction occupies D
//   dec_ra1/2, dec_use1/2     D source addresses and their read enables
//   dec_wa, dec_regwrite      D destination and write enable
//   dec_is_load               D instruction is a load (result ready in W)
//   branch_taken_e            branch in E resolved taken
//   stall_d                   hold PC and F/D, bubble into E
//   flush_fd, flush_e         clear F/D, bubble into D/E
//   fwd_a_e, fwd_b_e          registered E operand selects (00 RF, 01 M ALU, 10 W result)
//   stall_cnt, flush_cnt      saturating event counters
module asip_hazard_unit #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_ra1,
    input  logic [REG_AW-1:0] dec_ra2,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic [REG_AW-1:0] dec_wa,
    input  logic              dec_regwrite,
    input  logic              dec_is_load,
    input  logic              branch_taken_e,
    output logic              stall_d,
    output logic              flush_fd,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic              regwrite;
        logic              is_load;
    } shadow_t;

    shadow_t sh_e, sh_m, sh_w;
    shadow_t d_entry;
    logic    advance;
    logic    stall_raw;

    // Producer/consumer match for one source operand against one stage entry.
    function automatic logic hit(input shadow_t s, input logic used,
                                 input logic [REG_AW-1:0] ra);
        return s.valid && s.regwrite && used && (ra == s.wa);
    endfunction

    logic m1_e, m2_e, m1_m, m2_m, m1_w, m2_w;

    assign m1_e = hit(sh_e, dec_use1, dec_ra1);
    assign m2_e = hit(sh_e, dec_use2, dec_ra2);
    assign m1_m = hit(sh_m, dec_use1, dec_ra1);
    assign m2_m = hit(sh_m, dec_use2, dec_ra2);
    assign m1_w = hit(sh_w, dec_use1, dec_ra1);
    assign m2_w = hit(sh_w, dec_use2, dec_ra2);

    assign d_entry = {1'b1, dec_wa, dec_regwrite, dec_is_load};

`ifdef ASIP_FWD_EN
    // A load in E cannot be forwarded yet. It costs one bubble, and after that
    // the load is in M and the W result is forwarded to E.
    assign stall_raw = sh_e.is_load && (m1_e || m2_e);
`else
    // The register file is written at the end of W. A consumer waits until
    // no E, M or W entry still holds its source.
    assign stall_raw = m1_e || m2_e || m1_m || m2_m || m1_w || m2_w;
`endif

    // The reset gating keeps the combinational controls at zero while the
    // unit is in reset, even when the branch input toggles.
    // A taken branch overrides a pending stall.
    assign stall_d  = rst && dec_valid && stall_raw && !branch_taken_e;
    assign flush_fd = rst && branch_taken_e;
    assign flush_e  = stall_d || flush_fd;
    assign advance  = dec_valid && !stall_d && !branch_taken_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_e <= '0;
            sh_m <= '0;
            sh_w <= '0;
        end else begin
            sh_w <= sh_m;
            sh_m <= sh_e;
            sh_e <= advance ? d_entry : '0;
        end
    end

`ifdef ASIP_FWD_EN
    logic [1:0] sel_a, sel_b;

    // The youngest producer has priority: a match in E takes precedence over
    // a match in M.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (m1_e && !sh_e.is_load) sel_a = 2'b01;
        else if (m1_m)             sel_a = 2'b10;
        if (m2_e && !sh_e.is_load) sel_b = 2'b01;
        else if (m2_m)             sel_b = 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_e <= 2'b00;
            fwd_b_e <= 2'b00;
        end else if (advance) begin
            fwd_a_e <= sel_a;
            fwd_b_e <= sel_b;
        end else begin
            fwd_a_e <= 2'b00;
            fwd_b_e <= 2'b00;
        end
    end
`else
    assign fwd_a_e = 2'b00;
    assign fwd_b_e = 2'b00;
`endif

    // Some shadow fields are consumed only in one build (the W entry, and the
    // load flags past E). They are collected here so that every field stays
    // observable and none of them is dangling.
    logic unused_shadow;
    assign unused_shadow = ^{sh_w, sh_m.is_load, sh_e.is_load};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (branch_taken_e && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_asip_hazard_unit.sv
// Directed-vector bench for asip_hazard_unit. The driver applies one
// instruction per cycle and queues the outputs it expects. A monitor on the
// falling edge pops the queue and compares the DUT outputs with each entry.
module tb_asip_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dec_valid, dec_use1, dec_use2, dec_regwrite, dec_is_load;
    logic [3:0] dec_ra1, dec_ra2, dec_wa;
    logic       branch_taken_e;
    logic       stall_d, flush_fd, flush_e;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [3:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    asip_hazard_unit #(.REG_AW(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
        .dec_use1(dec_use1), .dec_use2(dec_use2),
        .dec_wa(dec_wa), .dec_regwrite(dec_regwrite), .dec_is_load(dec_is_load),
        .branch_taken_e(branch_taken_e),
        .stall_d(stall_d), .flush_fd(flush_fd), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       st, ffd, fe;
        logic [1:0] fa, fb;
        int         sc, fc;
        bit         c_ctl, c_fwd, c_cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            if (me.c_ctl) begin
                checks++;
                if ({stall_d, flush_fd, flush_e} !== {me.st, me.ffd, me.fe}) begin
                    failures++;
                    $display("FAIL %s ctl: stall/flush_fd/flush_e got %b%b%b want %b%b%b",
                             me.nm, stall_d, flush_fd, flush_e, me.st, me.ffd, me.fe);
                end
            end
            if (me.c_fwd) begin
                checks++;
                if ({fwd_a_e, fwd_b_e} !== {me.fa, me.fb}) begin
                    failures++;
                    $display("FAIL %s fwd: a/b got %b/%b want %b/%b",
                             me.nm, fwd_a_e, fwd_b_e, me.fa, me.fb);
                end
            end
            if (me.c_cnt) begin
                checks++;
                if ((int'(stall_cnt) != me.sc) || (int'(flush_cnt) != me.fc)) begin
                    failures++;
                    $display("FAIL %s cnt: stall/flush got %0d/%0d want %0d/%0d",
                             me.nm, stall_cnt, flush_cnt, me.sc, me.fc);
                end
            end
        end
    end

    task automatic ins(input logic v, input logic [3:0] a1, input logic u1,
                       input logic [3:0] a2, input logic u2, input logic [3:0] wa,
                       input logic rw, input logic ld, input logic br);
        @(posedge clk);
        #1;
        dec_valid = v; dec_ra1 = a1; dec_use1 = u1; dec_ra2 = a2; dec_use2 = u2;
        dec_wa = wa; dec_regwrite = rw; dec_is_load = ld; branch_taken_e = br;
    endtask

    task automatic alu(input logic [3:0] wa, input logic [3:0] a1, input logic [3:0] a2);
        ins(1'b1, a1, 1'b1, a2, 1'b1, wa, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [3:0] wa, input logic [3:0] a1);
        ins(1'b1, a1, 1'b1, 4'd0, 1'b0, wa, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic nop(input logic br);
        ins(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, br);
    endtask

    task automatic ex(input string nm, input logic st, input logic ffd, input logic fe,
                      input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
        exp_t e;
        e.nm = nm; e.st = st; e.ffd = ffd; e.fe = fe; e.fa = fa; e.fb = fb;
        e.sc = sc; e.fc = fc; e.c_ctl = 1'b1; e.c_fwd = 1'b1; e.c_cnt = 1'b1;
        q.push_back(e);
    endtask

    task automatic exc(input string nm, input int sc, input int fc);
        exp_t e;
        e.nm = nm; e.st = 1'b0; e.ffd = 1'b0; e.fe = 1'b0; e.fa = 2'b00; e.fb = 2'b00;
        e.sc = sc; e.fc = fc; e.c_ctl = 1'b0; e.c_fwd = 1'b0; e.c_cnt = 1'b1;
        q.push_back(e);
    endtask

    // Reset is asserted asynchronously partway through a cycle, with random
    // inputs applied. Every output must be zero at once. The release cycle is
    // left idle.
    task automatic rst_seq(input string nm);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            dec_valid = 1'($urandom); dec_ra1 = 4'($urandom); dec_use1 = 1'($urandom);
            dec_ra2 = 4'($urandom); dec_use2 = 1'($urandom); dec_wa = 4'($urandom);
            dec_regwrite = 1'($urandom); dec_is_load = 1'($urandom);
            branch_taken_e = 1'($urandom);
            ex(nm, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        dec_valid = 1'b0; dec_use1 = 1'b0; dec_use2 = 1'b0; dec_regwrite = 1'b0;
        dec_is_load = 1'b0; branch_taken_e = 1'b0;
    endtask

    initial begin
        dec_valid = 1'b0; dec_ra1 = '0; dec_ra2 = '0; dec_use1 = 1'b0; dec_use2 = 1'b0;
        dec_wa = '0; dec_regwrite = 1'b0; dec_is_load = 1'b0; branch_taken_e = 1'b0;

        // Independent instruction after reset.
        rst_seq("reset0");
        alu(4'd7, 4'd2, 4'd3);  ex("indep_d", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(1'b0);              ex("indep_e", 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // Back-to-back ALU chain R1<=R2+R3 ; R4<=R1+R1.
        rst_seq("reset_chain");
        alu(4'd1, 4'd2, 4'd3);  ex("chain_p", 0, 0, 0, 2'b00, 2'b00, 0, 0);
`ifdef ASIP_FWD_EN
        alu(4'd4, 4'd1, 4'd1);  ex("chain_c", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(1'b0);              ex("chain_fwd", 0, 0, 0, 2'b01, 2'b01, 0, 0);
`else
        alu(4'd4, 4'd1, 4'd1);  ex("chain_st_e", 1, 0, 1, 2'b00, 2'b00, 0, 0);
        alu(4'd4, 4'd1, 4'd1);  ex("chain_st_m", 1, 0, 1, 2'b00, 2'b00, 1, 0);
        alu(4'd4, 4'd1, 4'd1);  ex("chain_st_w", 1, 0, 1, 2'b00, 2'b00, 2, 0);
        alu(4'd4, 4'd1, 4'd1);  ex("chain_go", 0, 0, 0, 2'b00, 2'b00, 3, 0);
        nop(1'b0);              ex("chain_end", 0, 0, 0, 2'b00, 2'b00, 3, 0);
`endif

        // Distance-2 dependency with an independent instruction between.
        rst_seq("reset_d2");
        alu(4'd1, 4'd2, 4'd3);  ex("d2_p", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        alu(4'd8, 4'd9, 4'd10); ex("d2_i", 0, 0, 0, 2'b00, 2'b00, 0, 0);
`ifdef ASIP_FWD_EN
        alu(4'd4, 4'd1, 4'd2);  ex("d2_c", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        nop(1'b0);              ex("d2_fwd", 0, 0, 0, 2'b10, 2'b00, 0, 0);
`else
        alu(4'd4, 4'd1, 4'd2);  ex("d2_st_m", 1, 0, 1, 2'b00, 2'b00, 0, 0);
        alu(4'd4, 4'd1, 4'd2);  ex("d2_st_w", 1, 0, 1, 2'b00, 2'b00, 1, 0);
        alu(4'd4, 4'd1, 4'd2);  ex("d2_go", 0, 0, 0, 2'b00, 2'b00, 2, 0);
        nop(1'b0);              ex("d2_end", 0, 0, 0, 2'b00, 2'b00, 2, 0);
`endif

        // Load-use: LD R5 ; ADD R6<=R5+R0.
        rst_seq("reset_lu");
        ld(4'd5, 4'd2);         ex("lu_ld", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        alu(4'd6, 4'd5, 4'd0);  ex("lu_st", 1, 0, 1, 2'b00, 2'b00, 0, 0);
`ifdef ASIP_FWD_EN
        alu(4'd6, 4'd5, 4'd0);  ex("lu_go", 0, 0, 0, 2'b00, 2'b00, 1, 0);
        nop(1'b0);              ex("lu_fwd", 0, 0, 0, 2'b10, 2'b00, 1, 0);
`else
        alu(4'd6, 4'd5, 4'd0);  ex("lu_st_m", 1, 0, 1, 2'b00, 2'b00, 1, 0);
        alu(4'd6, 4'd5, 4'd0);  ex("lu_st_w", 1, 0, 1, 2'b00, 2'b00, 2, 0);
        alu(4'd6, 4'd5, 4'd0);  ex("lu_go", 0, 0, 0, 2'b00, 2'b00, 3, 0);
        nop(1'b0);              ex("lu_end", 0, 0, 0, 2'b00, 2'b00, 3, 0);
`endif

        // Load-use stall pending while a branch is taken: the flush wins.
        rst_seq("reset_br");
        ld(4'd5, 4'd2);         ex("br_ld", 0, 0, 0, 2'b00, 2'b00, 0, 0);
        ins(1'b1, 4'd5, 1'b1, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
                                ex("br_flush", 0, 1, 1, 2'b00, 2'b00, 0, 0);
        nop(1'b0);              ex("br_after", 0, 0, 0, 2'b00, 2'b00, 0, 1);

        // Saturation: self-dependent loads stall at least every other cycle.
        rst_seq("reset_sat");
        for (int i = 0; i < 60; i++) ld(4'd5, 4'd5);
        nop(1'b0);              exc("stall_sat", 15, 0);
        for (int i = 0; i < 20; i++) nop(1'b1);
        nop(1'b0);              exc("flush_sat", 15, 15);
        nop(1'b0);              ex("sat_hold", 0, 0, 0, 2'b00, 2'b00, 15, 15);

        // Asserting reset with saturated counters clears them at once.
        rst_seq("reset_mid");
        nop(1'b0);              ex("post_reset", 0, 0, 0, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asip_hazard_unit.md
# asip_hazard_unit

Parametrised hazard and forwarding controller for the pipelined ASIP (F, D, E, M, W stages). It shadows the destination-register state of the E, M and W stages, detects read-after-write and load-use hazards for the instruction in D, and drives the D-stage stall and F/D flush controls. It also produces registered forwarding selects for the E-stage operand muxes and keeps saturating stall and flush event counters. It sits beside the controller and datapath in the core top level.

## Interface
- REG_AW, 4, register-address width; the register file holds 2^REG_AW registers, none hard-wired.
- CNT_W, 16, width of each performance counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- dec_valid  in  1  a real instruction occupies D.
- dec_ra1, dec_ra2  in  REG_AW  D-stage source register addresses.
- dec_use1, dec_use2  in  1  the corresponding source is actually read.
- dec_wa  in  REG_AW  D-stage destination register.
- dec_regwrite  in  1  D instruction writes the register file.
- dec_is_load  in  1  D instruction is a memory load; result is available only in W.
- branch_taken_e  in  1  the branch in E resolved taken (PCSrcE after condition logic).
- stall_d  out  1  hold PC and the F/D register; insert a bubble into E.
- flush_fd  out  1  clear the F/D register.
- flush_e  out  1  load a bubble into the D/E register.
- fwd_a_e, fwd_b_e  out  2  E-stage operand select: 00 register file, 01 ALU result in M, 10 resultW.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Internal shadow pipeline of 3 entries (E, M, W), each {valid, wa, regwrite, is_load}. Every cycle W<=M and M<=E. E<=D fields when D advances; otherwise E<=bubble (valid=0).
- D advances when dec_valid=1, stall_d=0 and branch_taken_e=0.
- A match means: entry valid, entry regwrite=1, dec_useN=1, and dec_raN==entry.wa.
- Load-use: an E-entry match with is_load=1 gives stall_d=1. Active in both configurations.
- Branch: branch_taken_e=1 gives flush_fd=1, flush_e=1 and stall_d=0. The flush overrides any stall in the same cycle.
- flush_e = stall_d | branch_taken_e.
- Forward select computed in D, registered into E when D advances (00 on a bubble). Per operand: E-entry match (non-load) -> 01; else M-entry match -> 10; else 00. The youngest producer wins.
- When D is not valid, stall_d=0 and no stall is counted.
- stall_cnt increments on each cycle with stall_d=1. flush_cnt increments on each cycle with branch_taken_e=1. Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- stall_d, flush_fd and flush_e are combinational from the current shadow state, the dec_* inputs and branch_taken_e. They are valid in the same cycle.
- fwd_a_e and fwd_b_e are registered and valid the cycle the consumer is in E.
- Load-use penalty is exactly 1 cycle with forwarding. A taken-branch penalty is 2 bubbles.
- Reset values: all shadow entries invalid; stall_d, flush_fd, flush_e = 0; fwd_a_e, fwd_b_e = 00; both counters = 0.
- Asserting rst mid-stall or mid-flush clears everything immediately. The first cycle after release behaves as an empty pipeline.
- The register file is written at the end of W and read combinationally in D. A W-entry match is therefore stale and is handled per Configuration.

## Configuration
- ASIP_FWD_EN defined: forwarding as in Operation. Only load-use causes stalls.
- ASIP_FWD_EN undefined:
  - fwd_a_e and fwd_b_e are tied to 00.
  - stall_d=1 on any match against the E, M or W entry, loads included.
  - A dependent instruction waits up to 3 cycles.
  - Branch behaviour and counters are unchanged.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0/00; release, issue an independent instruction -> stall_d=0, fwd 00.
- ALU chain: R1<=R2+R3 then R4<=R1+R1 back-to-back.
  - FWD_EN: no stall; fwd_a_e=fwd_b_e=01 for the consumer in E.
  - Without FWD_EN: stall_d high for 3 cycles; stall_cnt=3.
- Distance-2 dependency: R1 producer, one independent instruction, then a consumer of R1. FWD_EN -> fwd_a_e=10, no stall.
- Load-use: LD R5 then ADD R6<=R5+R0 -> stall_d=1 for exactly 1 cycle, then fwd_a_e=10; stall_cnt=1.
- Simultaneous event: load-use stall pending while branch_taken_e=1 -> flush_fd=1, flush_e=1, stall_d=0; flush_cnt=1, stall_cnt unchanged.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
